// File: rtl/route_comp_buf_if.sv
// rtl/route_comp_buf_if.sv - flit input and routed-head output handshake bundle
interface route_comp_buf_if #(
  parameter int COORD_W   = 3,
  parameter int PAYLOAD_W = 32,
  parameter int NUM_PORT  = 5
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [COORD_W-1:0]   in_dst_x;
  logic [COORD_W-1:0]   in_dst_y;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 out_valid;
  logic                 out_ready;
  logic [NUM_PORT-1:0]  out_prod_vec;
  logic [PAYLOAD_W-1:0] out_payload;

  modport master (
    output in_valid, in_dst_x, in_dst_y, in_payload, out_ready,
    input  in_ready, out_valid, out_prod_vec, out_payload
  );

  modport slave (
    input  in_valid, in_dst_x, in_dst_y, in_payload, out_ready,
    output in_ready, out_valid, out_prod_vec, out_payload
  );
endinterface

// File: rtl/route_comp_buf.sv
// rtl/route_comp_buf.sv - registered route computation stage with output FIFO
// Define ROUTE_STATS_EN to add per-direction route counters (stat_clr/stat_cnt).
module route_comp_buf #(
  parameter int COORD_W   = 3,
  parameter int PAYLOAD_W = 32,
  parameter int DEPTH     = 2,
  parameter int NUM_PORT  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [COORD_W-1:0]      cur_x,
  input  logic [COORD_W-1:0]      cur_y,
  input  logic                    mode,
`ifdef ROUTE_STATS_EN
  input  logic                    stat_clr,
  output logic [NUM_PORT*16-1:0]  stat_cnt,
`endif
  route_comp_buf_if.slave         bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [NUM_PORT-1:0]  vec_q [DEPTH];
  logic [NUM_PORT-1:0]  vec_d [DEPTH];
  logic [PAYLOAD_W-1:0] pay_q [DEPTH];
  logic [PAYLOAD_W-1:0] pay_d [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  logic [COORD_W:0]     delta_x, delta_y;
  logic                 done_x, done_y;
  logic [NUM_PORT-1:0]  route_vec;
  logic                 push, pop;

  // Zero-extended subtraction: the MSB of the result is the direction sign.
  always_comb begin
    delta_x   = {1'b0, bus.in_dst_x} - {1'b0, cur_x};
    delta_y   = {1'b0, bus.in_dst_y} - {1'b0, cur_y};
    done_x    = (delta_x == '0);
    done_y    = (delta_y == '0);
    route_vec = '0;
    route_vec[0] = !done_x && !delta_x[COORD_W];
    route_vec[1] = !done_x &&  delta_x[COORD_W];
    if (mode || done_x) begin
      route_vec[2] = !done_y && !delta_y[COORD_W];
      route_vec[3] = !done_y &&  delta_y[COORD_W];
    end
    route_vec[4] = done_x && done_y;
  end

  assign bus.in_ready     = (count_q < CW'(DEPTH)) && !reset;
  assign bus.out_valid    = (count_q != '0);
  assign bus.out_prod_vec = vec_q[rd_ptr_q];
  assign bus.out_payload  = pay_q[rd_ptr_q];
  assign push             = bus.in_valid && bus.in_ready;
  assign pop              = bus.out_valid && bus.out_ready;

  always_comb begin
    vec_d    = vec_q;
    pay_d    = pay_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) begin
      vec_d[wr_ptr_q] = route_vec;
      pay_d[wr_ptr_q] = bus.in_payload;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        vec_q[i] <= '0;
        pay_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vec_q    <= vec_d;
      pay_q    <= pay_d;
    end
  end

`ifdef ROUTE_STATS_EN
  logic [15:0] cnt_q [NUM_PORT];
  logic [15:0] cnt_d [NUM_PORT];

  // Clear beats a concurrent accept; counters stick at all-ones.
  always_comb begin
    for (int i = 0; i < NUM_PORT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stat_clr) begin
        cnt_d[i] = '0;
      end else if (push && route_vec[i] && (cnt_q[i] != 16'hFFFF)) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORT; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_PORT; g++) begin : g_stat
    assign stat_cnt[16*g +: 16] = cnt_q[g];
  end
`endif
endmodule

// File: tb/tb_route_comp_buf.sv
// tb/tb_route_comp_buf.sv - randomized scoreboard bench for route_comp_buf
module tb_route_comp_buf;
  localparam int COORD_W   = 3;
  localparam int PAYLOAD_W = 32;
  localparam int DEPTH     = 2;
  localparam int NUM_PORT  = 5;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [COORD_W-1:0] cur_x = '0;
  logic [COORD_W-1:0] cur_y = '0;
  logic               mode = 1'b0;

  route_comp_buf_if #(.COORD_W(COORD_W), .PAYLOAD_W(PAYLOAD_W), .NUM_PORT(NUM_PORT)) bus ();

`ifdef ROUTE_STATS_EN
  logic                   stat_clr = 1'b0;
  logic [NUM_PORT*16-1:0] stat_cnt;
  bit                     clr_req = 1'b0;
  int                     scnt [NUM_PORT];
`endif

  route_comp_buf #(
    .COORD_W(COORD_W), .PAYLOAD_W(PAYLOAD_W), .DEPTH(DEPTH), .NUM_PORT(NUM_PORT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cur_x    (cur_x),
    .cur_y    (cur_y),
    .mode     (mode),
`ifdef ROUTE_STATS_EN
    .stat_clr (stat_clr),
    .stat_cnt (stat_cnt),
`endif
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_PORT-1:0]  vec;
    logic [PAYLOAD_W-1:0] pay;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   occ = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Direction rules from signed coordinate differences.
  function automatic logic [NUM_PORT-1:0] ref_route(int cx, int cy, int dx, int dy, bit m);
    int ddx = dx - cx;
    int ddy = dy - cy;
    logic [NUM_PORT-1:0] v = '0;
    if (ddx == 0 && ddy == 0) return 5'b10000;
    if (ddx > 0) v[0] = 1'b1;
    if (ddx < 0) v[1] = 1'b1;
    if (m || ddx == 0) begin
      if (ddy > 0) v[2] = 1'b1;
      if (ddy < 0) v[3] = 1'b1;
    end
    return v;
  endfunction

  // Monitor: one sample per cycle, 1 unit after the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("out_valid", bus.out_valid, sb.size() != 0);
      if (bus.out_valid && sb.size() != 0) begin
        chk("out_prod_vec", bus.out_prod_vec, sb[0].vec);
        chk("out_payload", bus.out_payload, sb[0].pay);
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic step(input bit rst, input bit v, input int dx, input int dy,
                      input logic [31:0] p, input bit ordy,
                      input int cx, input int cy, input bit m, output bit acc);
    bit exp_rdy;
    logic [NUM_PORT-1:0] rv;
    @(negedge clk);
    reset          = rst;
    bus.in_valid   = v;
    bus.in_dst_x   = COORD_W'(dx);
    bus.in_dst_y   = COORD_W'(dy);
    bus.in_payload = p;
    bus.out_ready  = ordy;
    cur_x          = COORD_W'(cx);
    cur_y          = COORD_W'(cy);
    mode           = m;
`ifdef ROUTE_STATS_EN
    stat_clr       = clr_req;
`endif
    #3;
    exp_rdy = (occ < DEPTH) && !rst;
    chk("in_ready", bus.in_ready, exp_rdy);
    acc = v && bus.in_ready;
    rv  = ref_route(cx, cy, dx, dy, m);
`ifdef ROUTE_STATS_EN
    for (int i = 0; i < NUM_PORT; i++) begin
      chk("stat_cnt", stat_cnt[16*i +: 16], 128'(scnt[i]));
      if (rst || clr_req) scnt[i] = 0;
      else if (acc && rv[i] && scnt[i] < 16'hFFFF) scnt[i]++;
    end
`endif
    if (rst) begin
      occ = 0;
      sb.delete();
    end else begin
      if (ordy && occ > 0) occ--;
      if (acc) begin
        occ++;
        sb.push_back('{vec: rv, pay: p});
      end
    end
  endtask

  task automatic idle(input bit ordy);
    bit a;
    step(1'b0, 1'b0, 0, 0, 32'h0, ordy, int'(cur_x), int'(cur_y), mode, a);
  endtask

  task automatic route_case(input string name, input int cx, input int cy, input bit m,
                            input int dx, input int dy, input logic [NUM_PORT-1:0] want);
    bit a;
    step(1'b0, 1'b1, dx, dy, $urandom, 1'b1, cx, cy, m, a);
    chk({name, "_acc"}, a, 1'b1);
    idle(1'b1);
    chk(name, bus.out_prod_vec, want);
  endtask

  task automatic reset_zero_check(input string name);
    chk({name, "_valid"}, bus.out_valid, 1'b0);
    chk({name, "_vec"}, bus.out_prod_vec, 0);
    chk({name, "_pay"}, bus.out_payload, 0);
  endtask

  initial begin
    bit a;
    bus.in_valid = 1'b0; bus.in_dst_x = '0; bus.in_dst_y = '0;
    bus.in_payload = '0; bus.out_ready = 1'b0;
`ifdef ROUTE_STATS_EN
    for (int i = 0; i < NUM_PORT; i++) scnt[i] = 0;
`endif
    step(1'b1, 1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b0, a);
    step(1'b1, 1'b1, 0, 0, 0, 1'b0, 0, 0, 1'b0, a);
    chk("rst_no_accept", a, 1'b0);
    idle(1'b0);
    reset_zero_check("reset");

    route_case("xy_east",  2, 2, 1'b0, 5, 1, 5'b00001);
    route_case("xy_local", 2, 2, 1'b0, 2, 2, 5'b10000);
    route_case("ad_wn",    4, 4, 1'b1, 1, 6, 5'b00110);
    route_case("xy_west",  4, 4, 1'b0, 1, 6, 5'b00010);
    route_case("ad_ext",   7, 0, 1'b1, 0, 7, 5'b00110);
    route_case("xy_south", 3, 5, 1'b0, 3, 0, 5'b01000);
    idle(1'b1);

    // Fill with no consumer, then try to push in the same cycle a pop happens.
    step(1'b0, 1'b1, 1, 1, 32'hA000_0001, 1'b0, 0, 0, 1'b0, a); chk("full_acc0", a, 1'b1);
    step(1'b0, 1'b1, 2, 1, 32'hA000_0002, 1'b0, 0, 0, 1'b0, a); chk("full_acc1", a, 1'b1);
    step(1'b0, 1'b1, 3, 1, 32'hA000_0003, 1'b0, 0, 0, 1'b0, a); chk("full_acc2", a, 1'b0);
    step(1'b0, 1'b1, 3, 1, 32'hA000_0003, 1'b1, 0, 0, 1'b0, a); chk("full_nobypass", a, 1'b0);
    step(1'b0, 1'b1, 3, 1, 32'hA000_0003, 1'b1, 0, 0, 1'b0, a); chk("full_acc3", a, 1'b1);
    repeat (3) idle(1'b1);

    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, i, 7 - i, 32'hB000_0000 + i, 1'b1, 3, 3, i[0], a);
      chk("stream_acc", a, 1'b1);
    end
    repeat (2) idle(1'b1);

    step(1'b0, 1'b1, 6, 6, 32'hC000_0001, 1'b0, 1, 1, 1'b1, a);
    step(1'b0, 1'b1, 0, 6, 32'hC000_0002, 1'b0, 1, 1, 1'b1, a);
    step(1'b1, 1'b0, 0, 0, 32'h0, 1'b0, 1, 1, 1'b1, a);
    idle(1'b0);
    reset_zero_check("midreset");

`ifdef ROUTE_STATS_EN
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1, 4, 32'hD000_0000 + i, 1'b1, 4, 4, 1'b0, a);
    idle(1'b1);
    chk("stat_bit1", stat_cnt[31:16], 16'd3);
    clr_req = 1'b1;
    step(1'b0, 1'b1, 1, 4, 32'hD000_0003, 1'b1, 4, 4, 1'b0, a);
    clr_req = 1'b0;
    idle(1'b1);
    chk("stat_clr", stat_cnt[31:16], 16'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 3) != 0,
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 1) == 1, a);
    end
    repeat (4) idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
